// File: rtl/fir_output_stage.sv
// fir_output_stage: rounds, scales and saturates MAC results, queues them in a show-ahead FIFO with back-pressure and sticky stats
module fir_output_stage #(
    parameter int ACC_WIDTH  = 19,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ACC_WIDTH-1:0] i_acc_data,
    input  logic                 i_acc_valid,
    output logic                 o_acc_ready,
    output logic [OUT_WIDTH-1:0] o_out_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    input  logic                 i_clear_flags,
    output logic                 o_overflow_sticky,
    output logic [CNT_WIDTH-1:0] o_sat_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ACC_WIDTH:0] RND = ((ACC_WIDTH+1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_WIDTH:0] MAXV = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH:0] MINV = -MAXV - 1;

    logic signed [ACC_WIDTH:0] w_ext, w_rnd, w_shr;
    logic                      w_hi, w_lo, w_sat, w_accept, w_drop, w_push, w_pop;
    logic [OUT_WIDTH-1:0]      w_out;
    logic [PW+1:0]             w_occ;

    logic                      r_stage_valid;
    logic [OUT_WIDTH-1:0]      r_stage_data;
    logic [OUT_WIDTH-1:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]             r_wr, r_rd;
    logic [PW:0]               r_count;
    logic                      r_ovf;
    logic [CNT_WIDTH-1:0]      r_sat_count;

    assign w_ext = {i_acc_data[ACC_WIDTH-1], i_acc_data};
    assign w_rnd = w_ext + $signed(RND);
    assign w_shr = w_rnd >>> SHIFT;
    assign w_hi  = w_shr > MAXV;
    assign w_lo  = w_shr < MINV;
    assign w_sat = w_hi | w_lo;
    assign w_out = w_hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
                   w_lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : w_shr[OUT_WIDTH-1:0];

    // A slot is reserved for the staged sample, so readiness counts it as occupied
    assign w_occ       = {1'b0, r_count} + (PW+2)'(r_stage_valid);
    assign o_acc_ready = w_occ < (PW+2)'(FIFO_DEPTH);
    assign w_accept    = i_acc_valid & o_acc_ready;
    assign w_drop      = i_acc_valid & ~o_acc_ready;
    assign o_out_valid = r_count != '0;
    assign w_pop       = o_out_valid & i_out_ready;
    assign w_push      = r_stage_valid;
    assign o_out_data  = r_mem[r_rd];

    assign o_overflow_sticky = r_ovf;
    assign o_sat_count       = r_sat_count;

    // Stage register holds the rounded/saturated sample for one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stage_valid <= 1'b0;
            r_stage_data  <= '0;
        end else begin
            r_stage_valid <= w_accept;
            if (w_accept) r_stage_data <= w_out;
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_mem[r_wr] <= r_stage_data;
            r_wr    <= r_wr + PW'(w_push);
            r_rd    <= r_rd + PW'(w_pop);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // Sticky statistics; a same-cycle event overrides clear_flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf       <= 1'b0;
            r_sat_count <= '0;
        end else begin
            r_ovf       <= w_drop | (r_ovf & ~i_clear_flags);
            r_sat_count <= (w_accept & w_sat) ?
                               (i_clear_flags ? CNT_WIDTH'(1) : r_sat_count + CNT_WIDTH'(~&r_sat_count)) :
                               (i_clear_flags ? '0 : r_sat_count);
        end
    end
endmodule

// File: tb/tb_fir_output_stage.sv
// tb_fir_output_stage: directed vector table plus hand-written sequences for fir_output_stage
module tb_fir_output_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] acc_data = '0;
    logic        acc_valid = 1'b0;
    logic        acc_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        clear_flags = 1'b0;
    logic        overflow_sticky;
    logic [7:0]  sat_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [18:0] acc;
        logic [7:0]  dout;
        logic [7:0]  sat;
    } vec_t;

    vec_t vecs[13];

    fir_output_stage dut (
        .clock(clock),
        .reset(reset),
        .i_acc_data(acc_data),
        .i_acc_valid(acc_valid),
        .o_acc_ready(acc_ready),
        .o_out_data(out_data),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .i_clear_flags(clear_flags),
        .o_overflow_sticky(overflow_sticky),
        .o_sat_count(sat_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{19'(320),     8'h03, 8'd0};
        vecs[1]  = '{19'(-320),    8'hFE, 8'd0};
        vecs[2]  = '{19'(20000),   8'h7F, 8'd1};
        vecs[3]  = '{19'(-20000),  8'h80, 8'd2};
        vecs[4]  = '{19'(-262144), 8'h80, 8'd3};
        vecs[5]  = '{19'(63),      8'h00, 8'd3};
        vecs[6]  = '{19'(64),      8'h01, 8'd3};
        vecs[7]  = '{19'(-65),     8'hFF, 8'd3};
        vecs[8]  = '{19'(16319),   8'h7F, 8'd3};
        vecs[9]  = '{19'(16320),   8'h7F, 8'd4};
        vecs[10] = '{19'(-16448),  8'h80, 8'd4};
        vecs[11] = '{19'(-16449),  8'h80, 8'd5};
        vecs[12] = '{19'(262143),  8'h7F, 8'd6};

        repeat (2) @(negedge clock);
        check("rst_ready", acc_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow_sticky, 0);
        check("rst_sat", sat_count, 0);
        reset = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            acc_valid = 1'b1;
            acc_data  = vecs[i].acc;
            @(negedge clock);
            acc_valid = 1'b0;
            check("vec_lat1_valid", out_valid, 0);
            @(negedge clock);
            check("vec_valid", out_valid, 1);
            check("vec_data", out_data, vecs[i].dout);
            check("vec_sat", sat_count, vecs[i].sat);
            @(negedge clock);
            check("vec_one_cycle", out_valid, 0);
        end

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("fill_ready", acc_ready, i < 4);
            acc_valid = 1'b1;
            acc_data  = 19'((i + 1) * 128);
        end
        @(negedge clock);
        acc_valid = 1'b0;
        check("full_ovf", overflow_sticky, 1);
        check("full_ready", acc_ready, 0);
        check("full_valid", out_valid, 1);
        check("drain_data", out_data, 1);
        out_ready = 1'b1;
        for (int j = 2; j <= 4; j++) begin
            @(negedge clock);
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, j);
        end
        @(negedge clock);
        check("drain_empty", out_valid, 0);
        check("drain_ready", acc_ready, 1);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            acc_valid = 1'b1;
            acc_data  = 19'((i + 5) * 128);
        end
        @(negedge clock);
        acc_valid = 1'b0;
        @(negedge clock);
        check("pp_full_ready", acc_ready, 0);
        check("pp_head", out_data, 5);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("pp_ready_after_pop", acc_ready, 1);
        check("pp_head2", out_data, 6);
        acc_valid = 1'b1;
        acc_data  = 19'(9 * 128);
        @(negedge clock);
        acc_valid = 1'b0;
        check("pp_ready_reserved", acc_ready, 0);
        out_ready = 1'b1;
        for (int j = 7; j <= 9; j++) begin
            @(negedge clock);
            check("pp_valid", out_valid, 1);
            check("pp_order", out_data, j);
        end
        @(negedge clock);
        check("pp_empty", out_valid, 0);

        clear_flags = 1'b1;
        @(negedge clock);
        clear_flags = 1'b0;
        check("clr_ovf", overflow_sticky, 0);
        check("clr_sat", sat_count, 0);
        clear_flags = 1'b1;
        acc_valid   = 1'b1;
        acc_data    = 19'(20000);
        @(negedge clock);
        clear_flags = 1'b0;
        check("clr_vs_sat", sat_count, 1);

        begin
            int bubbles = 0;
            for (int k = 0; k < 254; k++) begin
                @(negedge clock);
                if (!acc_ready || !out_valid || out_data !== 8'h7F) bubbles++;
            end
            check("sat_pin_255", sat_count, 255);
            repeat (3) @(negedge clock);
            check("sat_hold_255", sat_count, 255);
            check("throughput_bubbles", bubbles, 0);
        end
        acc_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("stream_drained", out_valid, 0);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            acc_valid = 1'b1;
            acc_data  = 19'((i + 1) * 128);
        end
        @(negedge clock);
        acc_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_ready", acc_ready, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", acc_ready, 1);
        check("mid_rst_ovf", overflow_sticky, 0);
        check("mid_rst_sat", sat_count, 0);
        check("mid_rst_data", out_data, 0);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        acc_valid = 1'b1;
        acc_data  = 19'(640);
        @(negedge clock);
        acc_valid = 1'b0;
        check("post_rst_lat1", out_valid, 0);
        @(negedge clock);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", out_data, 5);
        @(negedge clock);
        check("post_rst_empty", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
